mem_access_unit: RTL
====================

# mem_access_unit

Memory-stage access controller sitting between the EX/MEM pipeline register and the data memory. Accepts one word-sized load or store request at a time and drives the memory's read/write strobes, address and write data stable for a fixed number of cycles. Captures load data and stalls the pipeline until the access completes. Rejects misaligned, out-of-range or conflicting requests without touching memory.

## Interface
- MEM_LATENCY, 2, cycles the memory needs with strobes, address and data held stable (legal 1..15)
- DEPTH_WORDS, 32, number of 32-bit words in the data memory; word index must be < DEPTH_WORDS
---
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-low reset
- req_read_i  in  1  load request from EX/MEM (MemRead)
- req_write_i  in  1  store request from EX/MEM (MemWrite)
- addr_i  in  32  byte address (ALU result)
- wdata_i  in  32  store data
- stall_o  out  1  hold PC, IF/ID, ID/EX, EX/MEM this cycle
- rdata_o  out  32  captured load data, held until next load completes
- rdata_valid_o  out  1  one-cycle pulse: rdata_o is new
- err_o  out  1  one-cycle pulse: request rejected
- mem_read_o  out  1  to memory MemRead_i
- mem_write_o  out  1  to memory MemWrite_i
- mem_addr_o  out  32  to memory Addr_i
- mem_wdata_o  out  32  to memory WriteData_i
- mem_rdata_i  in  32  from memory ReadData_o

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE: a request is present when req_read_i or req_write_i is high.
  - On a request, stall_o = 1 combinationally and the request is latched into addr, wdata and op registers.
  - Request is an error if any of these holds: both req inputs high; addr_i[1:0] != 0; addr_i[31:2] >= DEPTH_WORDS.
  - Error -> DONE, with no memory strobes ever asserted.
  - Valid request -> ACCESS, with the counter loaded to 0.
- ACCESS:
  - Registered outputs mem_read_o/mem_write_o = latched op; mem_addr_o/mem_wdata_o = latched values.
  - stall_o = 1; counter increments each cycle.
  - In the cycle counter == MEM_LATENCY-1: a read samples mem_rdata_i into rdata_o at the clock edge; FSM -> DONE.
- DONE:
  - Strobes low; stall_o = 0.
  - rdata_valid_o = 1 if the op was a read; err_o = 1 if rejected.
  - Request inputs are ignored, because EX/MEM still holds the completed request. FSM -> IDLE.
- Neither req high in IDLE: stall_o = 0, no state change.
- mem_addr_o/mem_wdata_o keep their last values outside ACCESS. Only the strobes qualify them.
- Width rule: word index = addr_i[31:2]; the compare is unsigned 30-bit against DEPTH_WORDS.

## Timing
- Reset (asynchronous, immediate, mid-access included):
  - State -> IDLE, counter 0.
  - All outputs 0: stall_o, rdata_o, rdata_valid_o, err_o, mem_read_o, mem_write_o, mem_addr_o, mem_wdata_o.
  - An interrupted store may or may not have been written; no completion pulse is issued.
- Valid access presented in cycle 0:
  - stall_o high in cycles 0..MEM_LATENCY (MEM_LATENCY+1 cycles).
  - Strobes high in cycles 1..MEM_LATENCY.
  - DONE, and the rdata_valid_o pulse, in cycle MEM_LATENCY+1; rdata_o is valid from that cycle on.
- Rejected request in cycle 0: stall_o high in cycle 0 only; err_o pulse in cycle 1.
- Back-to-back requests: the next request is seen in IDLE at cycle MEM_LATENCY+2. There is no overlap and no bubble beyond the DONE cycle.
- Strobes, address and data are stable (no glitches) across ACCESS, because they are driven from flops.
- A store with MEM_LATENCY > 1 re-writes the same word each cycle; this is harmless.

## Structure
- Shared include mem_stage_defs.vh holds:
  - state encodings (IDLE=2'd0, ACCESS=2'd1, DONE=2'd2)
  - op encoding (OP_READ, OP_WRITE)
  - default MEM_LATENCY and DEPTH_WORDS
- One sub-module, latency_counter: 4-bit, with load-zero, enable and terminal-count output (count == MEM_LATENCY-1).
- The FSM, request latch and error check stay in mem_access_unit.

## Test plan
- Reset then idle: rst_i low for 2 cycles then high, no requests -> all outputs 0, stall_o 0 indefinitely.
- Store then load, MEM_LATENCY=2: write 0xDEADBEEF to 0x10, then read 0x10.
  - Store: strobes high for 2 cycles; stall_o high for 3 cycles.
  - Load: rdata_o = 0xDEADBEEF with rdata_valid_o pulsing in cycle 3.
- Errors: read at 0x12, write at 4*DEPTH_WORDS, and both reqs high at 0x0 -> each gives err_o pulse in cycle 1, stall_o only in cycle 0, mem strobes never high.
- Back-to-back loads from 0x0 and 0x4 with a memory model holding 0x11 and 0x22 -> valid pulses 4 cycles apart carrying 0x11 then 0x22, with no duplicate access to 0x0.
- Reset mid-access: assert rst_i in cycle 1 of a MEM_LATENCY=4 load -> strobes and stall_o drop immediately, no rdata_valid_o; after release, a fresh load completes normally.
- MEM_LATENCY=1 sweep: load from 0x8 -> strobe high 1 cycle, stall_o 2 cycles, valid pulse in cycle 2.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared types, defaults and request-checking helper for the memory-stage access unit.
package mem_access_unit_pkg;

  localparam int unsigned DEFAULT_MEM_LATENCY = 2;
  localparam int unsigned DEFAULT_DEPTH_WORDS = 32;
  localparam int unsigned CNT_W               = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

  // Misaligned byte address, or word index past the end of memory (unsigned 30-bit compare).
  function automatic logic addr_bad(input logic [31:0] addr, input int unsigned depth_words);
    return (addr[1:0] != 2'b00) || (addr[31:2] >= 30'(depth_words));
  endfunction

endpackage

// File: rtl/mem_access_unit_latency_counter.sv
// Up-counter timing the memory access window; tc_o flags the last cycle of the window.
module latency_counter
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned TC_VALUE = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = (count_q == CNT_W'(TC_VALUE));

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage access controller: one load/store at a time, strobes held from flops
// for MEM_LATENCY cycles, pipeline stalled until the access completes.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   ST_IDLE   | waiting for a request; stall combinationally while one is present
//   ST_ACCESS | strobes/address/data driven to memory, counting latency
//   ST_DONE   | completion cycle: rdata_valid_o or err_o pulse, no stall
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = DEFAULT_MEM_LATENCY,
  parameter int unsigned DEPTH_WORDS = DEFAULT_DEPTH_WORDS
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_read_i,
  input  logic        req_write_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        stall_o,
  output logic [31:0] rdata_o,
  output logic        rdata_valid_o,
  output logic        err_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i
);

  state_e      state_q, state_d;
  op_e         op_q, op_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rdata_valid_q, rdata_valid_d;
  logic        err_q, err_d;

  logic req;
  logic req_bad;
  logic cnt_clr;
  logic cnt_en;
  logic cnt_tc;

  assign req     = req_read_i | req_write_i;
  assign req_bad = (req_read_i & req_write_i) | addr_bad(addr_i, DEPTH_WORDS);

  latency_counter #(
    .TC_VALUE (MEM_LATENCY - 1)
  ) u_lat_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .tc_o  (cnt_tc)
  );

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    mem_read_d    = mem_read_q;
    mem_write_d   = mem_write_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    rdata_d       = rdata_q;
    rdata_valid_d = 1'b0;
    err_d         = 1'b0;
    cnt_clr       = 1'b0;
    cnt_en        = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          op_d = req_write_i ? OP_WRITE : OP_READ;
          if (req_bad) begin
            // Rejected requests never reach the memory pins.
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            mem_read_d  = req_read_i;
            mem_write_d = req_write_i;
            mem_addr_d  = addr_i;
            mem_wdata_d = wdata_i;
            cnt_clr     = 1'b1;
            state_d     = ST_ACCESS;
          end
        end
      end
      ST_ACCESS: begin
        cnt_en = 1'b1;
        if (cnt_tc) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          if (op_q == OP_READ) begin
            rdata_d       = mem_rdata_i;
            rdata_valid_d = 1'b1;
          end
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        // EX/MEM still holds the finished request here, so inputs are ignored.
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q       <= ST_IDLE;
      op_q          <= OP_READ;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      err_q         <= err_d;
    end
  end

  // Gated by reset so stall drops immediately even while a request is still presented.
  assign stall_o = rst_i & ((state_q == ST_ACCESS) | ((state_q == ST_IDLE) & req));

  assign rdata_o       = rdata_q;
  assign rdata_valid_o = rdata_valid_q;
  assign err_o         = err_q;
  assign mem_read_o    = mem_read_q;
  assign mem_write_o   = mem_write_q;
  assign mem_addr_o    = mem_addr_q;
  assign mem_wdata_o   = mem_wdata_q;

endmodule
